alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
Issue-side front end for the on-core ALU. It accepts operation requests from decode over a valid/ready handshake and buffers them in an in-order FIFO. It drives the combinational ALU's operand and opcode inputs from the FIFO head and registers the ALU result with the request tag. It returns responses to writeback over a second valid/ready handshake.

Parameters:
WORD_LEN, 64, operand/result width
TAG_LEN, 4, width of the opaque request tag returned with each result
DEPTH, 4, request FIFO entries; power of two, >= 2

Ports:
clk_i  input  1  core clock
rst_ni  input  1  reset; asynchronous assert, active-low
flush_i  input  1  synchronous flush of all buffered and in-flight work
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready
req_opc_i  input  alu_op_t  requested operation
req_a_i  input  WORD_LEN  operand A
req_b_i  input  WORD_LEN  operand B
req_tag_i  input  TAG_LEN  request tag
alu_op_a_o  output  WORD_LEN  to ALU operand A
alu_op_b_o  output  WORD_LEN  to ALU operand B
alu_opc_o  output  alu_op_t  to ALU opcode
alu_res_i  input  WORD_LEN  from ALU result (combinational)
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response ready
rsp_res_o  output  WORD_LEN  result
rsp_tag_o  output  TAG_LEN  tag of the request that produced rsp_res_o
rsp_err_o  output  1  request carried an unsupported opcode
count_o  output  $clog2(DEPTH+1)  FIFO occupancy, excluding the output register

Behaviour:
- Reset (rst_ni=0, any cycle, including mid-operation):
  - FIFO pointers and count go to 0; all buffered and in-flight requests are discarded.
  - rsp_valid_o=0; rsp_res_o, rsp_tag_o, rsp_err_o = 0; count_o=0.
  - req_ready_o=1 from the first cycle after release.
- Push: occurs on an edge where req_valid_i && req_ready_o.
- req_ready_o = (count != DEPTH). No same-cycle pass-through when full, even if a pop happens in that cycle.
- Pop: occurs on an edge where count != 0 && (!rsp_valid_o || rsp_ready_i).
  - On pop, the output register loads alu_res_i, the head tag, and the error flag, and sets rsp_valid_o=1.
- Response holds: if rsp_valid_o && rsp_ready_i && count==0, rsp_valid_o clears on that edge. While rsp_valid_o && !rsp_ready_i, all rsp_* outputs stay stable.
- ALU drive:
  - FIFO non-empty: alu_op_a_o, alu_op_b_o, alu_opc_o come combinationally from the FIFO head.
  - FIFO empty: the ALU is quiesced with op_a=0, op_b=0, opc=ALU_OP_ADD.
- Latency: a request pushed at edge k gives rsp_valid_o=1 after edge k+1, provided the output register is free. Sustained throughput is 1 per cycle.
- Ordering: strict FIFO. Responses leave in acceptance order.
- Legal opcodes are ALU_OP_ADD and ALU_OP_SUB. Any other value still pops normally, with rsp_err_o=1 and rsp_res_o=0.
- Arithmetic is modulo 2^WORD_LEN with no carry or overflow output; SUB wraps.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- flush_i=1 at an edge:
  - Takes priority over push and pop.
  - count=0, pointers=0, rsp_valid_o=0.
  - A request presented in the same cycle is dropped even though req_ready_o may have been 1.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full and empty are derived from the pointers and must agree with count_o.

Decomposition:
- The shared ALU package holds alu_op_t (ALU_OP_ADD, ALU_OP_SUB) plus a new function alu_op_legal(alu_op_t) returning 1 for the supported opcodes. alu_dispatch uses that function; no local opcode list.
- One sub-module, alu_dispatch_fifo: a parameterised synchronous FIFO.
  - Parameters: width, DEPTH.
  - Ports: push, pop, flush, full, empty, count, head data.
  - The entry is {opc, a, b, tag} packed.
- alu_dispatch owns the handshake logic, ALU drive, and output register. The ALU itself is instantiated beside it by the parent execute stage.

Test Plan:
1. Reset:
   - Stimulus: assert rst_ni=0 asynchronously with 3 requests buffered and rsp_valid_o=1.
   - Response: rsp_valid_o=0 and count_o=0 immediately; after release req_ready_o=1 and no stale responses appear.
2. Single ADD latency:
   - Stimulus: ADD a=5, b=7, tag=3 accepted at edge k, with rsp_ready_i=1.
   - Response: rsp_valid_o=1 after edge k+1 with rsp_res_o=12, rsp_tag_o=3, rsp_err_o=0; deasserts after edge k+2.
3. SUB wrap:
   - Stimulus: SUB a=0, b=1.
   - Response: rsp_res_o=0xFFFF_FFFF_FFFF_FFFF.
4. Back-to-back with backpressure (DEPTH=4):
   - Stimulus: rsp_ready_i=0, push tags 0..4 on consecutive cycles.
   - Response: all 5 accepted, then req_ready_o=0 with count_o=4 and rsp_tag_o=0 held stable.
   - Then raise rsp_ready_i: tags 0,1,2,3,4 arrive on 5 consecutive cycles with correct sums, and req_ready_o=1 one cycle after the first pop.
5. Illegal opcode:
   - Stimulus: unsupported alu_op_t value, tag=9.
   - Response: rsp_err_o=1, rsp_res_o=0, rsp_tag_o=9; the following legal ADD returns rsp_err_o=0.
6. Flush:
   - Stimulus: flush_i=1 with count_o=2, rsp_valid_o=1, and a simultaneous push of tag=7.
   - Response: next cycle count_o=0, rsp_valid_o=0, and tag 7 never appears on rsp_tag_o.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
// Shared ALU definitions: opcode encoding and the legality check used by issue logic.
package alu_dispatch_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_SUB = 2'd1
  } alu_op_t;

  // Returns 1 for opcodes the on-core ALU implements.
  function automatic logic alu_op_legal(input alu_op_t op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_dispatch_fifo.sv
// In-order request buffer. Pointers carry one extra wrap bit so full and
// empty fall out of a pointer compare, and occupancy is their difference.
module alu_dispatch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    diff;

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // Status derived purely from the pointers.
  always_comb begin
    diff    = wr_ptr_q - rd_ptr_q;
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    count_o = diff;
    head_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/alu_dispatch.sv
// ALU issue front end: buffers requests, drives the external combinational
// ALU from the buffer head and captures results in a response register.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int WORD_LEN = 64,
  parameter int TAG_LEN  = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  alu_op_t                    req_opc_i,
  input  logic [WORD_LEN-1:0]        req_a_i,
  input  logic [WORD_LEN-1:0]        req_b_i,
  input  logic [TAG_LEN-1:0]         req_tag_i,
  output logic [WORD_LEN-1:0]        alu_op_a_o,
  output logic [WORD_LEN-1:0]        alu_op_b_o,
  output alu_op_t                    alu_opc_o,
  input  logic [WORD_LEN-1:0]        alu_res_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [WORD_LEN-1:0]        rsp_res_o,
  output logic [TAG_LEN-1:0]         rsp_tag_o,
  output logic                       rsp_err_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int OPC_W   = $bits(alu_op_t);
  localparam int ENTRY_W = OPC_W + 2 * WORD_LEN + TAG_LEN;

  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [ENTRY_W-1:0] entry_in, head;
  alu_op_t            head_opc;
  logic [WORD_LEN-1:0] head_a, head_b;
  logic [TAG_LEN-1:0] head_tag;

  logic                rsp_valid_q, rsp_valid_d;
  logic [WORD_LEN-1:0] rsp_res_q,   rsp_res_d;
  logic [TAG_LEN-1:0]  rsp_tag_q,   rsp_tag_d;
  logic                rsp_err_q,   rsp_err_d;

  // Handshake: a pop needs a free (or draining) response register.
  always_comb begin
    req_ready_o = !fifo_full;
    push        = req_valid_i && !fifo_full && !flush_i;
    pop         = !fifo_empty && (!rsp_valid_q || rsp_ready_i) && !flush_i;
    entry_in    = {req_opc_i, req_a_i, req_b_i, req_tag_i};
  end

  alu_dispatch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (entry_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o),
    .head_o  (head)
  );

  // Unpack the head entry and drive the ALU; quiesce it to 0+0 when empty.
  always_comb begin
    head_tag   = head[TAG_LEN-1:0];
    head_b     = head[TAG_LEN +: WORD_LEN];
    head_a     = head[TAG_LEN+WORD_LEN +: WORD_LEN];
    head_opc   = alu_op_t'(head[ENTRY_W-1 -: OPC_W]);
    alu_op_a_o = '0;
    alu_op_b_o = '0;
    alu_opc_o  = ALU_OP_ADD;
    if (!fifo_empty) begin
      alu_op_a_o = head_a;
      alu_op_b_o = head_b;
      alu_opc_o  = head_opc;
    end
  end

  // Response register next state: flush clears, pop loads, accepted response drains.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (flush_i) begin
      rsp_valid_d = 1'b0;
    end else if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_tag_d   = head_tag;
      rsp_err_d   = !alu_op_legal(head_opc);
      rsp_res_d   = alu_op_legal(head_opc) ? alu_res_i : '0;
    end else if (rsp_valid_q && rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Output ports.
  always_comb begin
    rsp_valid_o = rsp_valid_q;
    rsp_res_o   = rsp_res_q;
    rsp_tag_o   = rsp_tag_q;
    rsp_err_o   = rsp_err_q;
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural ALU beside the DUT.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;

  localparam int WORD_LEN = 64;
  localparam int TAG_LEN  = 4;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH+1);

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic                req_valid_i;
  logic                req_ready_o;
  alu_op_t             req_opc_i;
  logic [WORD_LEN-1:0] req_a_i, req_b_i;
  logic [TAG_LEN-1:0]  req_tag_i;
  logic [WORD_LEN-1:0] alu_op_a_o, alu_op_b_o;
  alu_op_t             alu_opc_o;
  logic [WORD_LEN-1:0] alu_res_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [WORD_LEN-1:0] rsp_res_o;
  logic [TAG_LEN-1:0]  rsp_tag_o;
  logic                rsp_err_o;
  logic [CW-1:0]       count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  // Behavioural ALU; unsupported opcodes return junk the DUT must mask.
  always_comb begin
    case (alu_opc_o)
      ALU_OP_ADD: alu_res_i = alu_op_a_o + alu_op_b_o;
      ALU_OP_SUB: alu_res_i = alu_op_a_o - alu_op_b_o;
      default:    alu_res_i = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  end

  alu_dispatch #(.WORD_LEN(WORD_LEN), .TAG_LEN(TAG_LEN), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_opc_i   (req_opc_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_tag_i   (req_tag_i),
    .alu_op_a_o  (alu_op_a_o),
    .alu_op_b_o  (alu_op_b_o),
    .alu_opc_o   (alu_opc_o),
    .alu_res_i   (alu_res_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_res_o   (rsp_res_o),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_err_o   (rsp_err_o),
    .count_o     (count_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic v, input alu_op_t op, input logic [WORD_LEN-1:0] a,
                         input logic [WORD_LEN-1:0] b, input logic [TAG_LEN-1:0] tag);
    req_valid_i = v;
    req_opc_i   = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
  endtask

  task automatic test_reset();
    step();
    step();
    rst_ni = 1'b1;
    step();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rst_state: valid=%b count=%0d want 0/0", rsp_valid_o, count_o); end
    checks++; if (alu_opc_o !== ALU_OP_ADD || alu_op_a_o !== 64'd0 || alu_op_b_o !== 64'd0) begin errors++; $display("FAIL rst_quiesce: opc=%0d a=%0h b=%0h want 0/0/0", alu_opc_o, alu_op_a_o, alu_op_b_o); end
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, ALU_OP_ADD, 64'(i), 64'd1, 4'(i));
      step();
    end
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    checks++; if (count_o !== 3'd3 || rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rst_preload: count=%0d valid=%b want 3/1", count_o, rsp_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rst_async: valid=%b count=%0d want 0/0", rsp_valid_o, count_o); end
    checks++; if (rsp_res_o !== 64'd0 || rsp_tag_o !== 4'd0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_zero: res=%0h tag=%0d err=%b want 0", rsp_res_o, rsp_tag_o, rsp_err_o); end
    step();
    #2 rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_no_stale: valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o); end
    end
  endtask

  task automatic test_add();
    rsp_ready_i = 1'b1;
    set_req(1'b1, ALU_OP_ADD, 64'd5, 64'd7, 4'd3);
    step();
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    checks++; if (rsp_valid_o !== 1'b0 || count_o !== 3'd1) begin errors++; $display("FAIL add_k: valid=%b count=%0d want 0/1", rsp_valid_o, count_o); end
    checks++; if (alu_op_a_o !== 64'd5 || alu_op_b_o !== 64'd7 || alu_opc_o !== ALU_OP_ADD) begin errors++; $display("FAIL add_drive: a=%0d b=%0d want 5/7", alu_op_a_o, alu_op_b_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_res_o !== 64'd12 || rsp_tag_o !== 4'd3 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL add_rsp: valid=%b res=%0d tag=%0d err=%b want 1/12/3/0", rsp_valid_o, rsp_res_o, rsp_tag_o, rsp_err_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL add_drain: valid=%b want 0", rsp_valid_o); end
  endtask

  task automatic test_sub_wrap();
    rsp_ready_i = 1'b1;
    set_req(1'b1, ALU_OP_SUB, 64'd0, 64'd1, 4'd5);
    step();
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_res_o !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_tag_o !== 4'd5 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL sub_wrap: valid=%b res=%0h tag=%0d want 1/ffffffffffffffff/5", rsp_valid_o, rsp_res_o, rsp_tag_o); end
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: ready=%b want 1", i, req_ready_o); end
      set_req(1'b1, ALU_OP_ADD, 64'(i * 10), 64'd1, 4'(i));
      step();
    end
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    checks++; if (req_ready_o !== 1'b0 || count_o !== 3'd4) begin errors++; $display("FAIL b2b_full: ready=%b count=%0d want 0/4", req_ready_o, count_o); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd0 || rsp_res_o !== 64'd1) begin errors++; $display("FAIL b2b_hold: valid=%b tag=%0d res=%0d want 1/0/1", rsp_valid_o, rsp_tag_o, rsp_res_o); end
      step();
    end
    checks++; if (alu_op_a_o !== 64'd10 || alu_op_b_o !== 64'd1) begin errors++; $display("FAIL b2b_head: a=%0d b=%0d want 10/1", alu_op_a_o, alu_op_b_o); end
    rsp_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      checks++; if (rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'(i) || rsp_res_o !== 64'(i * 10 + 1)) begin errors++; $display("FAIL b2b_order%0d: valid=%b tag=%0d res=%0d want 1/%0d/%0d", i, rsp_valid_o, rsp_tag_o, rsp_res_o, i, i * 10 + 1); end
      if (i == 1) begin
        checks++; if (req_ready_o !== 1'b1 || count_o !== 3'd3) begin errors++; $display("FAIL b2b_ready_back: ready=%b count=%0d want 1/3", req_ready_o, count_o); end
      end
    end
    step();
    checks++; if (rsp_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty: valid=%b count=%0d want 0/0", rsp_valid_o, count_o); end
  endtask

  task automatic test_illegal();
    alu_op_t bad_op;
    bad_op = alu_op_t'(2'd2);
    rsp_ready_i = 1'b1;
    set_req(1'b1, bad_op, 64'd3, 64'd4, 4'd9);
    step();
    set_req(1'b1, ALU_OP_ADD, 64'd2, 64'd2, 4'd10);
    step();
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_res_o !== 64'd0 || rsp_tag_o !== 4'd9) begin errors++; $display("FAIL illegal_rsp: valid=%b err=%b res=%0h tag=%0d want 1/1/0/9", rsp_valid_o, rsp_err_o, rsp_res_o, rsp_tag_o); end
    step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_res_o !== 64'd4 || rsp_tag_o !== 4'd10) begin errors++; $display("FAIL illegal_next: valid=%b err=%b res=%0d tag=%0d want 1/0/4/10", rsp_valid_o, rsp_err_o, rsp_res_o, rsp_tag_o); end
    step();
  endtask

  task automatic test_flush();
    rsp_ready_i = 1'b0;
    for (int i = 1; i < 4; i++) begin
      set_req(1'b1, ALU_OP_ADD, 64'(i), 64'd0, 4'(i));
      step();
    end
    checks++; if (count_o !== 3'd2 || rsp_valid_o !== 1'b1 || rsp_tag_o !== 4'd1) begin errors++; $display("FAIL flush_pre: count=%0d valid=%b tag=%0d want 2/1/1", count_o, rsp_valid_o, rsp_tag_o); end
    set_req(1'b1, ALU_OP_ADD, 64'd7, 64'd7, 4'd7);
    flush_i = 1'b1;
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: ready=%b want 1", req_ready_o); end
    step();
    flush_i = 1'b0;
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    checks++; if (count_o !== 3'd0 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_clear: count=%0d valid=%b want 0/0", count_o, rsp_valid_o); end
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_dropped: valid=%b tag=%0d want no response", rsp_valid_o, rsp_tag_o); end
    end
    set_req(1'b1, ALU_OP_ADD, 64'd1, 64'd1, 4'd2);
    step();
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    step();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_res_o !== 64'd2 || rsp_tag_o !== 4'd2) begin errors++; $display("FAIL flush_recover: valid=%b res=%0d tag=%0d want 1/2/2", rsp_valid_o, rsp_res_o, rsp_tag_o); end
    step();
  endtask

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b0;
    set_req(1'b0, ALU_OP_ADD, 64'd0, 64'd0, 4'd0);
    test_reset();
    test_add();
    test_sub_wrap();
    test_back_to_back();
    test_illegal();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
